// File: rtl/pc_gen_if.sv
// Fetch-stage bus between pc_gen (master) and control / branch unit / instruction memory (slave).
interface pc_gen_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              stall;
    logic              flush;
    logic [ADDR_W-1:0] flush_pc;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    logic              if_ready;
    logic [ADDR_W-1:0] pc;
    logic              ce;
    logic              redir_pend;
    logic              pc_misalign;

    modport master (
        input  stall, flush, flush_pc, br_taken, br_target, if_ready,
        output pc, ce, redir_pend, pc_misalign
    );

    modport slave (
        output stall, flush, flush_pc, br_taken, br_target, if_ready,
        input  pc, ce, redir_pend, pc_misalign
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch program-counter generator with stall hold, fetch handshake, buffered branch and flush redirect.
// Optional alignment flag on redirected loads: define PC_ALIGN_CHECK_EN.
module pc_gen #(
    parameter int unsigned ADDR_W     = 32,
    parameter logic [31:0] RESET_VEC  = 32'hBFC00000,
    parameter int unsigned INST_BYTES = 4
) (
    input  logic     clk,
    input  logic     rst,
    pc_gen_if.master bus
);
    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(INST_BYTES);

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_q, pend_d;
    logic              rp_q, rp_d;
    logic              ce_q, ce_d;
    logic              adv;

    assign adv = ce_q & bus.if_ready & ~bus.stall;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next state: leave IDLE on the first edge out of reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Next pc / redirect buffer; flush beats branch beats pending beats sequential
    always_comb begin
        pc_d   = pc_q;
        pend_d = pend_q;
        rp_d   = rp_q;
        ce_d   = ce_q;
        case (state_q)
            IDLE: ce_d = 1'b1;
            RUN: begin
                ce_d = 1'b1;
                if (bus.flush) begin
                    pc_d = bus.flush_pc;
                    rp_d = 1'b0;
                end else if (bus.br_taken && adv) begin
                    pc_d = bus.br_target;
                    rp_d = 1'b0;
                end else if (bus.br_taken) begin
                    pend_d = bus.br_target;
                    rp_d   = 1'b1;
                end else if (rp_q && adv) begin
                    pc_d = pend_q;
                    rp_d = 1'b0;
                end else if (adv) begin
                    pc_d = pc_q + STEP;
                end
            end
            default: ce_d = 1'b0;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q   <= RST_PC;
            pend_q <= '0;
            rp_q   <= 1'b0;
            ce_q   <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            pend_q <= pend_d;
            rp_q   <= rp_d;
            ce_q   <= ce_d;
        end
    end

    assign bus.pc         = pc_q;
    assign bus.ce         = ce_q;
    assign bus.redir_pend = rp_q;

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INST_BYTES - 1);

    logic redir_load;
    logic mis_q;

    // Only redirected loads can introduce a misaligned pc
    assign redir_load = (state_q == RUN) &
                        (bus.flush | (bus.br_taken & adv) | (rp_q & adv));

    always_ff @(posedge clk) begin
        if (!rst) mis_q <= 1'b0;
        else      mis_q <= redir_load && ((pc_d & ALIGN_MASK) != '0);
    end

    assign bus.pc_misalign = mis_q;
`else
    assign bus.pc_misalign = 1'b0;
`endif
endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: expectations queued at drive time, popped and asserted after each edge.
module tb_pc_gen;
    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        ce;
        logic        rp;
        logic        mis;
    } exp_t;

`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;
    exp_t sb[$];

    pc_gen_if #(.ADDR_W(32)) bus ();

    pc_gen #(.ADDR_W(32), .RESET_VEC(32'hBFC00000), .INST_BYTES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed no $finish, required $finish");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic r, input logic st, input logic fl, input logic [31:0] fpc,
                         input logic br, input logic [31:0] bt, input logic rdy);
        rst           = r;
        bus.stall     = st;
        bus.flush     = fl;
        bus.flush_pc  = fpc;
        bus.br_taken  = br;
        bus.br_target = bt;
        bus.if_ready  = rdy;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] pc, input logic ce,
                              input logic rp, input logic mis);
        exp_t e;
        e.tag = tag; e.pc = pc; e.ce = ce; e.rp = rp; e.mis = mis;
        sb.push_back(e);
    endtask

    // Advance one edge, then compare every queued expectation against the outputs
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_total++;
            assert (bus.pc === e.pc) n_pass++;
            else $error("FAIL %s pc: observed %h expected %h", e.tag, bus.pc, e.pc);
            n_total++;
            assert (bus.ce === e.ce) n_pass++;
            else $error("FAIL %s ce: observed %b expected %b", e.tag, bus.ce, e.ce);
            n_total++;
            assert (bus.redir_pend === e.rp) n_pass++;
            else $error("FAIL %s redir_pend: observed %b expected %b", e.tag, bus.redir_pend, e.rp);
            n_total++;
            assert (bus.pc_misalign === e.mis) n_pass++;
            else $error("FAIL %s pc_misalign: observed %b expected %b", e.tag, bus.pc_misalign, e.mis);
        end
    endtask

    // Plain sequential/hold step: no flush, no branch
    task automatic run(input string tag, input logic st, input logic rdy,
                       input logic [31:0] pc, input logic rp);
        drive(1'b1, st, 1'b0, 32'h0, 1'b0, 32'h0, rdy);
        expect_out(tag, pc, 1'b1, rp, 1'b0);
        tick();
    endtask

    task automatic branch(input string tag, input logic rdy, input logic [31:0] bt,
                          input logic [31:0] pc, input logic rp, input logic mis);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, bt, rdy);
        expect_out(tag, pc, 1'b1, rp, mis);
        tick();
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            expect_out("t1_reset", 32'hBFC00000, 1'b0, 1'b0, 1'b0);
            tick();
        end
        // T1 boot: first fetch at the reset vector itself
        run("t1_boot",  1'b0, 1'b1, 32'hBFC00000, 1'b0);
        run("t1_seq1",  1'b0, 1'b1, 32'hBFC00004, 1'b0);
        run("t1_seq2",  1'b0, 1'b1, 32'hBFC00008, 1'b0);
        run("t1_seq3",  1'b0, 1'b1, 32'hBFC0000C, 1'b0);
        run("t1_seq4",  1'b0, 1'b1, 32'hBFC00010, 1'b0);
        // T2 stall then memory wait
        run("t2_stall", 1'b1, 1'b1, 32'hBFC00010, 1'b0);
        run("t2_stall", 1'b1, 1'b1, 32'hBFC00010, 1'b0);
        run("t2_wait",  1'b0, 1'b0, 32'hBFC00010, 1'b0);
        run("t2_wait",  1'b0, 1'b0, 32'hBFC00010, 1'b0);
        run("t2_adv",   1'b0, 1'b1, 32'hBFC00014, 1'b0);
        // T3 taken branch with adv
        branch("t3_br", 1'b1, 32'h80001000, 32'h80001000, 1'b0, 1'b0);
        // T4 buffered branch, newer target overwrites
        branch("t4_buf1", 1'b0, 32'h80002000, 32'h80001000, 1'b1, 1'b0);
        branch("t4_buf2", 1'b0, 32'h80003000, 32'h80001000, 1'b1, 1'b0);
        run("t4_hold",  1'b0, 1'b0, 32'h80001000, 1'b1);
        run("t4_stall", 1'b1, 1'b1, 32'h80001000, 1'b1);
        run("t4_apply", 1'b0, 1'b1, 32'h80003000, 1'b0);
        run("t4_seq",   1'b0, 1'b1, 32'h80003004, 1'b0);
        // Taken branch with adv supersedes an older pending target
        branch("sup_buf", 1'b0, 32'h80007000, 32'h80003004, 1'b1, 1'b0);
        branch("sup_br",  1'b1, 32'h80008000, 32'h80008000, 1'b0, 1'b0);
        run("sup_seq",  1'b0, 1'b1, 32'h80008004, 1'b0);
        // T5 flush collides with branch, stall and a pending redirect
        branch("t5_buf", 1'b0, 32'h80004000, 32'h80008004, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 32'hBFC00380, 1'b1, 32'h80005000, 1'b0);
        expect_out("t5_flush", 32'hBFC00380, 1'b1, 1'b0, 1'b0);
        tick();
        run("t5_seq",   1'b0, 1'b1, 32'hBFC00384, 1'b0);
        branch("t5_buf2", 1'b0, 32'h80006000, 32'hBFC00384, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        expect_out("t5_rst", 32'hBFC00000, 1'b0, 1'b0, 1'b0);
        tick();
        run("t5_boot",  1'b0, 1'b1, 32'hBFC00000, 1'b0);
        run("t5_seq2",  1'b0, 1'b1, 32'hBFC00004, 1'b0);
        // T6 wrap at the top of the address space
        drive(1'b1, 1'b0, 1'b1, 32'hFFFFFFF8, 1'b0, 32'h0, 1'b1);
        expect_out("t6_flush", 32'hFFFFFFF8, 1'b1, 1'b0, 1'b0);
        tick();
        run("t6_top",   1'b0, 1'b1, 32'hFFFFFFFC, 1'b0);
        run("t6_wrap",  1'b0, 1'b1, 32'h00000000, 1'b0);
        run("t6_post",  1'b0, 1'b1, 32'h00000004, 1'b0);
        // Misaligned redirect is loaded; flag only when the check is built in
        branch("t6_mis",  1'b1, 32'h80000002, 32'h80000002, 1'b0, ALIGN_EN);
        run("t6_misseq", 1'b0, 1'b1, 32'h80000006, 1'b0);
        branch("t6_mis2", 1'b1, 32'h80000011, 32'h80000011, 1'b0, ALIGN_EN);
        branch("t6_align", 1'b1, 32'h80000100, 32'h80000100, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
